count_seg_display: RTL and testbench

COUNT_SEG_DISPLAY -- requirements
Module: count_seg_display

---
 rtl/count_seg_display.sv | 156 +++++++++++++++
 tb/tb_count_seg_display.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seg_display.sv
// count_seg_display: four-digit multiplexed 7-segment driver for a 0..15 count.
// The value is shown in decimal on the two rightmost digits with leading-zero
// blanking. The displayed value is latched only at frame boundaries, so a
// mid-frame change of Count never tears. After each value change the
// decimal point on the units digit flashes for FLASH_FRAMES refresh frames.
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   Count[3:0] in   count value (asynchronous to frame timing)
//   Enable     in   0 blanks the display and freezes all refresh timing
//   An[3:0]    out  digit anodes, active-low one-hot, An[0] = rightmost
//   Seg[6:0]   out  segment cathodes, active-low, Seg[0]=a .. Seg[6]=g
//   Dp         out  decimal point cathode, active-low
//   Frame_tick out  one-cycle pulse per refresh frame
module count_seg_display #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned FLASH_FRAMES = 250
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Count,
  input  logic       Enable,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic       Frame_tick
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [9:0]       FLASH_LOAD = 10'(FLASH_FRAMES);
  localparam logic [6:0]       SEG_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {D0, D1, D2, D3} digit_t;

  digit_t            state;
  digit_t            state_nxt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [3:0]        count_q;
  logic [3:0]        disp_val;
  logic [9:0]        flash_cnt;
  logic              slot_tick_c;
  logic              frame_evt_c;
  logic              tens_c;
  logic [3:0]        units_c;
  logic [3:0]        an_nxt;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;

  // Active-low segment pattern for one decimal digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Slot timing: prescaler wraps at REFRESH_DIV-1 and only runs when enabled.
  assign slot_tick_c = Enable && (pre_cnt == PRE_LAST);

  // Decimal split of the latched value (0..15 needs at most one tens digit).
  assign tens_c  = (disp_val >= 4'd10);
  assign units_c = tens_c ? (disp_val - 4'd10) : disp_val;

  // Digit FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= D0;
    else       state <= state_nxt;
  end

  // Digit FSM next state; frame_evt_c marks the D3->D0 step.
  always_comb begin
    state_nxt   = state;
    frame_evt_c = 1'b0;
    if (slot_tick_c) begin
      case (state)
        D0:      state_nxt = D1;
        D1:      state_nxt = D2;
        D2:      state_nxt = D3;
        default: begin
          state_nxt   = D0;
          frame_evt_c = 1'b1;
        end
      endcase
    end
  end

  // Next values for the registered display outputs.
  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (Enable) begin
      case (state)
        D0: begin
          an_nxt  = 4'b1110;
          seg_nxt = seg_of(units_c);
          dp_nxt  = (flash_cnt == 10'd0);
        end
        D1: begin
          an_nxt  = 4'b1101;
          if (tens_c) seg_nxt = seg_of(4'd1);
        end
        D2:      an_nxt = 4'b1011;
        default: an_nxt = 4'b0111;
      endcase
    end
  end

  // Prescaler, input sampling, frame latch and flash counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pre_cnt   <= '0;
      count_q   <= 4'd0;
      disp_val  <= 4'd0;
      flash_cnt <= 10'd0;
    end else begin
      count_q <= Count;
      if (Enable) begin
        pre_cnt <= slot_tick_c ? '0 : pre_cnt + PRE_W'(1);
      end
      if (frame_evt_c) begin
        disp_val <= count_q;
        // A reload takes priority over the per-frame decrement.
        if (count_q != disp_val)      flash_cnt <= FLASH_LOAD;
        else if (flash_cnt != 10'd0)  flash_cnt <= flash_cnt - 10'd1;
      end
    end
  end

  // Registered outputs, one Clk behind the FSM state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      An         <= 4'b1111;
      Seg        <= SEG_BLANK;
      Dp         <= 1'b1;
      Frame_tick <= 1'b0;
    end else begin
      An         <= an_nxt;
      Seg        <= seg_nxt;
      Dp         <= dp_nxt;
      Frame_tick <= frame_evt_c;
    end
  end

endmodule

// File: tb/tb_count_seg_display.sv
// Bench for count_seg_display with REFRESH_DIV=4, FLASH_FRAMES=2.
// A behavioural model predicts {An,Seg,Dp,Frame_tick} at each rising edge and
// queues it; each scenario pops and compares one cycle later, plus a few
// model-independent checks on timing and flash length.
module tb_count_seg_display;

  localparam int RD = 4;
  localparam int FF = 2;
  localparam logic [12:0] BLANK_OBS = 13'b1111_1111111_1_0;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b1;
  logic [3:0] Count = 4'd0;
  logic [3:0] An;
  logic [6:0] Seg;
  logic       Dp;
  logic       Frame_tick;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int m_pre = 0, m_slot = 0, m_disp = 0, m_flash = 0, m_cq = 0;
  logic [12:0] exp_q[$];

  count_seg_display #(.REFRESH_DIV(RD), .FLASH_FRAMES(FF)) dut (
    .Clk(Clk), .Reset(Reset), .Count(Count), .Enable(Enable),
    .An(An), .Seg(Seg), .Dp(Dp), .Frame_tick(Frame_tick)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] pat_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_pre = 0; m_slot = 0; m_disp = 0; m_flash = 0; m_cq = 0;
  endtask

  // One clock: predict outputs from the pre-edge model state, then step it.
  task automatic advance();
    logic [12:0] e;
    @(posedge Clk);
    cyc++;
    if (!Enable) begin
      e = BLANK_OBS;
    end else begin
      e[12:9] = ~(4'b0001 << m_slot);
      e[8:2]  = 7'b1111111;
      e[1]    = 1'b1;
      if (m_slot == 0) begin
        e[8:2] = pat_of(m_disp % 10);
        e[1]   = (m_flash == 0);
      end
      if (m_slot == 1 && m_disp >= 10) e[8:2] = pat_of(1);
      e[0] = (m_pre == RD - 1) && (m_slot == 3);
      if (m_pre == RD - 1) begin
        m_pre = 0;
        if (m_slot == 3) begin
          m_slot = 0;
          if (m_cq != m_disp) begin
            m_disp  = m_cq;
            m_flash = FF;
          end else if (m_flash > 0) begin
            m_flash--;
          end
        end else begin
          m_slot++;
        end
      end else begin
        m_pre++;
      end
    end
    m_cq = int'(Count);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    int last_ft = -1;
    int n_ft = 0;
    logic [12:0] e;
    #12;
    total++;
    if ({An, Seg, Dp, Frame_tick} !== BLANK_OBS) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", {An, Seg, Dp, Frame_tick}, BLANK_OBS);
    end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    cyc = 0;
    for (int i = 0; i < 48; i++) begin
      advance();
      e = exp_q.pop_front();
      total++;
      if ({An, Seg, Dp, Frame_tick} !== e) begin
        bad++;
        $display("FAIL reset_run cyc=%0d got=%b exp=%b", cyc, {An, Seg, Dp, Frame_tick}, e);
      end
      if (i == 0) begin
        total++;
        if ({An, Seg} !== 11'b1110_1000000) begin
          bad++;
          $display("FAIL first_after_release got=%b exp=%b", {An, Seg}, 11'b1110_1000000);
        end
      end
      if (Frame_tick === 1'b1) begin
        n_ft++;
        if (last_ft >= 0) begin
          total++;
          if (cyc - last_ft != 16) begin
            bad++;
            $display("FAIL frame_period got=%0d exp=16", cyc - last_ft);
          end
        end
        last_ft = cyc;
      end
    end
    total++;
    if (n_ft != 3) begin
      bad++;
      $display("FAIL frame_tick_count got=%0d exp=3", n_ft);
    end
  endtask

  task automatic test_flash();
    int dp0 = 0, u3 = 0, t1 = 0;
    logic [12:0] e;
    Count = 4'd13;
    for (int i = 0; i < 96; i++) begin
      advance();
      e = exp_q.pop_front();
      total++;
      if ({An, Seg, Dp, Frame_tick} !== e) begin
        bad++;
        $display("FAIL flash cyc=%0d got=%b exp=%b", cyc, {An, Seg, Dp, Frame_tick}, e);
      end
      if (An === 4'b1110 && Dp === 1'b0) dp0++;
      if (An === 4'b1110 && Seg === 7'b0110000) u3++;
      if (An === 4'b1101 && Seg === 7'b1111001) t1++;
    end
    total++;
    if (dp0 != 8) begin
      bad++;
      $display("FAIL flash_len got=%0d exp=8", dp0);
    end
    total++;
    if (u3 == 0 || t1 == 0) begin
      bad++;
      $display("FAIL show_13 got units3=%0d tens1=%0d exp nonzero", u3, t1);
    end
  endtask

  task automatic test_no_tearing();
    int seen6 = 0, seen4 = 0;
    logic [12:0] e;
    Count = 4'd4;
    for (int i = 0; i < 80; i++) begin
      if (i == 35) Count = 4'd6;
      if (i == 39) Count = 4'd4;
      advance();
      e = exp_q.pop_front();
      total++;
      if ({An, Seg, Dp, Frame_tick} !== e) begin
        bad++;
        $display("FAIL no_tear cyc=%0d got=%b exp=%b", cyc, {An, Seg, Dp, Frame_tick}, e);
      end
      if (Seg === 7'b0000010) seen6++;
      if (i >= 32 && An === 4'b1110 && Seg === 7'b0011001) seen4++;
    end
    total++;
    if (seen6 != 0 || seen4 != 12) begin
      bad++;
      $display("FAIL tear_value got six=%0d four=%0d exp six=0 four=12", seen6, seen4);
    end
  endtask

  task automatic test_enable_gap();
    int start_cyc = cyc;
    int ft_cyc = -1;
    int guard = 0;
    logic [12:0] e;
    while (!(m_slot == 2 && m_pre == 1) && guard < 32) begin
      advance();
      void'(exp_q.pop_front());
      guard++;
    end
    Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      advance();
      e = exp_q.pop_front();
      total++;
      if ({An, Seg, Dp, Frame_tick} !== BLANK_OBS || e !== BLANK_OBS) begin
        bad++;
        $display("FAIL gap_blank cyc=%0d got=%b exp=%b", cyc, {An, Seg, Dp, Frame_tick}, BLANK_OBS);
      end
    end
    Enable = 1'b1;
    for (int i = 0; i < 40 && ft_cyc < 0; i++) begin
      advance();
      e = exp_q.pop_front();
      total++;
      if ({An, Seg, Dp, Frame_tick} !== e) begin
        bad++;
        $display("FAIL resume cyc=%0d got=%b exp=%b", cyc, {An, Seg, Dp, Frame_tick}, e);
      end
      if (Frame_tick === 1'b1) ft_cyc = cyc;
    end
    total++;
    if (ft_cyc != start_cyc + 26) begin
      bad++;
      $display("FAIL stretched_frame got=%0d exp=%0d", ft_cyc, start_cyc + 26);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int dp0 = 0;
    logic [12:0] e;
    Count = 4'd9;
    while (!(m_flash == 1 && m_slot == 3) && guard < 100) begin
      advance();
      void'(exp_q.pop_front());
      guard++;
    end
    total++;
    if (guard >= 100) begin
      bad++;
      $display("FAIL reach_flash1 got=timeout exp=flash1_in_D3");
    end
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    total++;
    if ({An, Seg, Dp, Frame_tick} !== BLANK_OBS) begin
      bad++;
      $display("FAIL async_blank got=%b exp=%b", {An, Seg, Dp, Frame_tick}, BLANK_OBS);
    end
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      advance();
      e = exp_q.pop_front();
      total++;
      if ({An, Seg, Dp, Frame_tick} !== e) begin
        bad++;
        $display("FAIL after_reset cyc=%0d got=%b exp=%b", cyc, {An, Seg, Dp, Frame_tick}, e);
      end
      if (i == 0) begin
        total++;
        if ({An, Seg, Dp} !== 12'b1110_1000000_1) begin
          bad++;
          $display("FAIL reset_d0 got=%b exp=%b", {An, Seg, Dp}, 12'b1110_1000000_1);
        end
      end
      if (Dp === 1'b0) dp0++;
    end
    total++;
    if (dp0 != 0) begin
      bad++;
      $display("FAIL reset_dp got=%0d exp=0", dp0);
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    int dp0 = 0;
    logic [12:0] e;
    while (m_flash != 1 && guard < 64) begin
      advance();
      void'(exp_q.pop_front());
      guard++;
    end
    Count = 4'd2;
    for (int i = 0; i < 64; i++) begin
      advance();
      e = exp_q.pop_front();
      total++;
      if ({An, Seg, Dp, Frame_tick} !== e) begin
        bad++;
        $display("FAIL reload cyc=%0d got=%b exp=%b", cyc, {An, Seg, Dp, Frame_tick}, e);
      end
      if (An === 4'b1110 && Dp === 1'b0) dp0++;
    end
    total++;
    if (dp0 != 12) begin
      bad++;
      $display("FAIL reload_wins got=%0d exp=12", dp0);
    end
  endtask

  initial begin
    test_reset();
    test_flash();
    test_no_tearing();
    test_enable_gap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
